// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   state_t      - access FSM states (IDLE, REQ, WAIT)
//   LB..SW       - funct3 encodings for loads and stores
//   size_t       - access width decoded from funct3[1:0]
//   access_size  - funct3 -> access width; 011/110/111 decode as word
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic size_t access_size(input logic [2:0] f3);
        if (f3[1:0] == LB[1:0]) begin
            return SZ_BYTE;
        end else if (f3[1:0] == LH[1:0]) begin
            return SZ_HALF;
        end else begin
            return SZ_WORD;
        end
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane formatting for the memory stage.
//   i_funct3      access size / signedness
//   i_addr_lo     byte offset within the word
//   i_store_data  store value (rs2)
//   i_resp_data   word returned by the data cache
//   o_wmask       byte-enable mask for the store
//   o_wdata       store value replicated across lanes
//   o_load_data   selected and sign/zero-extended load value
//   o_misaligned  access crosses its natural alignment
module mem_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_resp_data,
    output logic [3:0]      o_wmask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_misaligned
);

    size_t           w_size;
    logic            w_sext;
    logic [XLEN-1:0] w_lane;

    assign w_size = access_size(i_funct3);
    // funct3[2] marks the unsigned load variants
    assign w_sext = ~i_funct3[2];
    // Shift the addressed byte/half down to bit 0
    assign w_lane = i_resp_data >> {i_addr_lo, 3'b000};

    always_comb begin
        o_wmask      = '1;
        o_wdata      = i_store_data;
        o_load_data  = i_resp_data;
        o_misaligned = 1'b0;
        case (w_size)
            SZ_BYTE: begin
                o_wmask     = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{w_lane[7] & w_sext}}, w_lane[7:0]};
            end
            SZ_HALF: begin
                o_wmask      = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_lane[15] & w_sext}}, w_lane[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage downstream of execute.
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     instruction presented by execute
//   stall                    execute must hold its inputs (access in flight)
//   dc_req_* / dc_resp_*     data-cache request handshake and load response
//   wb_valid/data/rd/reg_we  registered writeback bundle (also forwarding source)
//   misaligned               one-cycle pulse: access dropped for misalignment
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_we,
    input  logic            ex_mem_re,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_we,
    output logic            stall,
    output logic            dc_req_valid,
    input  logic            dc_req_ready,
    output logic            dc_req_we,
    output logic [XLEN-1:0] dc_req_addr,
    output logic [XLEN-1:0] dc_req_wdata,
    output logic [3:0]      dc_req_wmask,
    input  logic            dc_resp_valid,
    input  logic [XLEN-1:0] dc_resp_data,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_we,
    output logic            misaligned
);

    state_t          r_state;
    state_t          w_next_state;

    // Held memory access
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_sdata;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_is_store;
    logic            r_reg_we;

    // Writeback bundle
    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_data;
    logic [4:0]      r_wb_rd;
    logic            r_wb_reg_we;
    logic            r_misaligned;

    logic            w_idle;
    logic            w_is_mem;
    logic            w_accept;
    logic [2:0]      w_funct3;
    logic [1:0]      w_addr_lo;
    logic [3:0]      w_wmask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;
    logic            w_misaligned;

    assign w_idle   = (r_state == IDLE);
    assign w_is_mem = ex_mem_we | ex_mem_re;
    assign w_accept = w_idle & ex_valid;

    // One aligner serves both phases: in IDLE it checks the incoming EX
    // access for misalignment, otherwise it formats the held access.
    assign w_funct3  = w_idle ? ex_funct3 : r_funct3;
    assign w_addr_lo = w_idle ? ex_result[1:0] : r_addr[1:0];

    mem_align #(.XLEN(XLEN)) u_align (
        .i_funct3     (w_funct3),
        .i_addr_lo    (w_addr_lo),
        .i_store_data (r_sdata),
        .i_resp_data  (dc_resp_data),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = (r_state != IDLE);
        dc_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex_valid && w_is_mem && !w_misaligned) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                dc_req_valid = 1'b1;
                if (dc_req_ready) begin
                    w_next_state = r_is_store ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dc_resp_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign dc_req_we    = r_is_store;
    assign dc_req_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign dc_req_wdata = w_wdata;
    assign dc_req_wmask = w_wmask;

    // Access capture; contents only matter while the FSM is out of IDLE
    always_ff @(posedge clk) begin
        if (w_accept && w_is_mem) begin
            r_addr     <= ex_result;
            r_sdata    <= ex_store_data;
            r_funct3   <= ex_funct3;
            r_rd       <= ex_rd;
            r_is_store <= ex_mem_we;
            r_reg_we   <= ex_reg_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_reg_we  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_wb_reg_we  <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ex_valid && !w_is_mem) begin
                        r_wb_valid  <= 1'b1;
                        r_wb_data   <= ex_result;
                        r_wb_rd     <= ex_rd;
                        r_wb_reg_we <= ex_reg_we;
                    end else if (ex_valid && w_misaligned) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_rd      <= ex_rd;
                        r_misaligned <= 1'b1;
                    end
                end
                REQ: begin
                    if (dc_req_ready && r_is_store) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                    end
                end
                WAIT: begin
                    if (dc_resp_valid) begin
                        r_wb_valid  <= 1'b1;
                        r_wb_data   <= w_load_data;
                        r_wb_rd     <= r_rd;
                        r_wb_reg_we <= r_reg_we;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_rd      = r_wb_rd;
    assign wb_reg_we  = r_wb_reg_we;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (table vectors, random
// traffic against a reference model, hand-written multi-cycle sequences).
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_we;
    logic        ex_mem_re;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        stall;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic        dc_req_we;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_wdata;
    logic [3:0]  dc_req_wmask;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_data;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic        misaligned;

    mem_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_mem_we     (ex_mem_we),
        .ex_mem_re     (ex_mem_re),
        .ex_rd         (ex_rd),
        .ex_reg_we     (ex_reg_we),
        .stall         (stall),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_we     (dc_req_we),
        .dc_req_addr   (dc_req_addr),
        .dc_req_wdata  (dc_req_wdata),
        .dc_req_wmask  (dc_req_wmask),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_data  (dc_resp_data),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_we     (wb_reg_we),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // kind: 0 = ALU op, 1 = load, 2 = store
    typedef struct {
        string       name;
        int          kind;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] sdata;
        logic [31:0] resp;
        logic [4:0]  rd;
        bit          reg_we;
        int          rdly;
        int          wdly;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_addr;
        bit          e_mis;
        bit          e_we;
        int          e_lat;
        int          e_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int kind, input logic [2:0] f3,
                                input logic [31:0] res, input logic [31:0] sdata,
                                input logic [31:0] resp, input logic [4:0] rd, input bit reg_we,
                                input int rdly, input int wdly, input logic [31:0] e_data,
                                input logic [3:0] e_mask, input logic [31:0] e_wdata,
                                input logic [31:0] e_addr, input bit e_mis, input bit e_we,
                                input int e_lat, input int e_stall);
        vec_t v;
        v.name = name; v.kind = kind; v.f3 = f3; v.res = res; v.sdata = sdata;
        v.resp = resp; v.rd = rd; v.reg_we = reg_we; v.rdly = rdly; v.wdly = wdly;
        v.e_data = e_data; v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_addr = e_addr;
        v.e_mis = e_mis; v.e_we = e_we; v.e_lat = e_lat; v.e_stall = e_stall;
        return v;
    endfunction

    // Reference model: expected outcome from the access rules alone.
    function automatic void model(inout vec_t v);
        int unsigned       off;
        int unsigned       sz;
        int unsigned       bits;
        longint unsigned   val;
        off = int'(v.res[1:0]);
        sz  = int'(v.f3[1:0]);
        if (sz == 3) sz = 2;
        v.e_addr  = v.res - off;
        v.e_mis   = (v.kind != 0) && ((sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0));
        v.e_data  = v.res;
        v.e_mask  = 4'b0000;
        v.e_wdata = 32'h0;
        v.e_we    = v.reg_we;
        v.e_lat   = 1;
        v.e_stall = 0;
        if (v.kind != 0 && v.e_mis) begin
            v.e_we = 1'b0;
        end else if (v.kind == 2) begin
            v.e_we    = 1'b0;
            v.e_lat   = 2 + v.rdly;
            v.e_stall = 1 + v.rdly;
            if (sz == 0) begin
                v.e_mask  = 4'(1 << off);
                v.e_wdata = (v.sdata % 256) * 32'h01010101;
            end else if (sz == 1) begin
                v.e_mask  = 4'(3 << off);
                v.e_wdata = (v.sdata % 65536) * 32'h00010001;
            end else begin
                v.e_mask  = 4'b1111;
                v.e_wdata = v.sdata;
            end
        end else if (v.kind == 1) begin
            v.e_lat   = 3 + v.rdly + v.wdly;
            v.e_stall = 2 + v.rdly + v.wdly;
            bits = 8 << sz;
            val  = (longint'(v.resp) >> (8 * off)) % (64'd1 << bits);
            if (v.f3 < 3'd4 && sz < 2 && val >= (64'd1 << (bits - 1)))
                val = val + (64'h1_0000_0000 - (64'd1 << bits));
            v.e_data = 32'(val);
        end
    endfunction

    // Issue one instruction, play the cache, observe and compare.
    task automatic run(input vec_t v);
        int          req_seen  = 0;
        int          wait_seen = 0;
        int          stall_cnt = 0;
        int          lat       = 0;
        bit          got       = 0;
        bit          req_any   = 0;
        bit          unstable  = 0;
        logic [31:0] a_addr  = '0;
        logic [31:0] a_wdata = '0;
        logic [3:0]  a_mask  = '0;
        logic        a_we    = 1'b0;
        logic [31:0] a_data  = '0;
        logic [4:0]  a_rd    = '0;
        logic        a_rwe   = 1'b0;
        logic        a_mis   = 1'b0;

        @(negedge clk);
        chk({v.name, "/stall_at_issue"}, stall, 1'b0);
        ex_valid      = 1'b1;
        ex_result     = v.res;
        ex_store_data = v.sdata;
        ex_funct3     = v.f3;
        ex_mem_we     = (v.kind == 2);
        ex_mem_re     = (v.kind == 1);
        ex_rd         = v.rd;
        ex_reg_we     = v.reg_we;
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;

        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            ex_valid      = 1'b0;
            dc_req_ready  = 1'b0;
            dc_resp_valid = 1'b0;
            dc_resp_data  = $urandom();
            if (stall) stall_cnt++;
            if (wb_valid) begin
                got = 1; lat = k; a_data = wb_data; a_rd = wb_rd;
                a_rwe = wb_reg_we; a_mis = misaligned;
            end
            if (dc_req_valid) begin
                if (!req_any) begin
                    req_any = 1; a_addr = dc_req_addr; a_wdata = dc_req_wdata;
                    a_mask = dc_req_wmask; a_we = dc_req_we;
                end else if (dc_req_addr !== a_addr || dc_req_wdata !== a_wdata ||
                             dc_req_wmask !== a_mask || dc_req_we !== a_we) begin
                    unstable = 1;
                end
                dc_req_ready = (req_seen == v.rdly);
                // A stray response while still requesting must be ignored
                if (!dc_req_ready) dc_resp_valid = 1'b1;
                req_seen++;
            end else if (stall) begin
                dc_resp_valid = (wait_seen == v.wdly);
                if (dc_resp_valid) dc_resp_data = v.resp;
                wait_seen++;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s/wb_timeout: got no wb_valid expected one within 60 cycles", v.name);
        end
        @(negedge clk);
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;
        chk({v.name, "/wb_pulse"}, wb_valid, 1'b0);
        chk({v.name, "/mis_pulse"}, misaligned, 1'b0);

        chk({v.name, "/latency"}, lat, v.e_lat);
        chk({v.name, "/stall_cycles"}, stall_cnt, v.e_stall);
        chk({v.name, "/misaligned"}, a_mis, v.e_mis);
        chk({v.name, "/reg_we"}, a_rwe, v.e_we);
        chk({v.name, "/req_issued"}, req_any, (v.kind != 0) && !v.e_mis);
        if (!(v.kind != 0 && v.e_mis)) chk({v.name, "/rd"}, a_rd, v.rd);
        if (v.kind == 0 || (v.kind == 1 && !v.e_mis)) chk({v.name, "/wb_data"}, a_data, v.e_data);
        if (v.kind != 0 && !v.e_mis) begin
            chk({v.name, "/req_addr"}, a_addr, v.e_addr);
            chk({v.name, "/req_we"}, a_we, (v.kind == 2));
            chk({v.name, "/req_stable"}, unstable, 1'b0);
        end
        if (v.kind == 2 && !v.e_mis) begin
            chk({v.name, "/wmask"}, a_mask, v.e_mask);
            chk({v.name, "/wdata"}, a_wdata, v.e_wdata);
        end
    endtask

    vec_t tbl[15];

    initial begin
        vec_t v;
        int   load_k;
        int   alu_k;
        int   wb_cnt;
        int   req_seen;
        bit   drop;

        tbl[0]  = mk("alu",      0, 3'b000, 32'h1234, 0, 0, 5, 1, 0, 0,
                     32'h1234, 4'b0000, 0, 0, 0, 1, 1, 0);
        tbl[1]  = mk("sb",       2, SB, 32'h103, 32'hAB, 0, 6, 0, 0, 0,
                     0, 4'b1000, 32'hABABABAB, 32'h100, 0, 0, 2, 1);
        tbl[2]  = mk("lb",       1, LB, 32'h102, 0, 32'h80FF7F00, 7, 1, 0, 1,
                     32'hFFFFFFFF, 4'b0000, 0, 32'h100, 0, 1, 4, 3);
        tbl[3]  = mk("lbu",      1, LBU, 32'h102, 0, 32'h80FF7F00, 7, 1, 0, 1,
                     32'h000000FF, 4'b0000, 0, 32'h100, 0, 1, 4, 3);
        tbl[4]  = mk("lh_mis",   1, LH, 32'h101, 0, 32'h12345678, 8, 1, 0, 0,
                     0, 4'b0000, 0, 32'h100, 1, 0, 1, 0);
        tbl[5]  = mk("sh",       2, SH, 32'h202, 32'h1234ABCD, 0, 0, 0, 2, 0,
                     0, 4'b1100, 32'hABCDABCD, 32'h200, 0, 0, 4, 3);
        tbl[6]  = mk("lw",       1, LW, 32'h40, 0, 32'hDEADBEEF, 10, 1, 1, 0,
                     32'hDEADBEEF, 4'b0000, 0, 32'h40, 0, 1, 4, 3);
        tbl[7]  = mk("lhu",      1, LHU, 32'h42, 0, 32'h80011234, 11, 1, 0, 0,
                     32'h00008001, 4'b0000, 0, 32'h40, 0, 1, 3, 2);
        tbl[8]  = mk("lh",       1, LH, 32'h42, 0, 32'h80011234, 11, 1, 0, 0,
                     32'hFFFF8001, 4'b0000, 0, 32'h40, 0, 1, 3, 2);
        tbl[9]  = mk("sw_mis",   2, SW, 32'h12, 32'h55, 0, 12, 0, 0, 0,
                     0, 4'b0000, 0, 32'h10, 1, 0, 1, 0);
        tbl[10] = mk("lw_f3_011", 1, 3'b011, 32'h44, 0, 32'h11223344, 13, 1, 0, 0,
                     32'h11223344, 4'b0000, 0, 32'h44, 0, 1, 3, 2);
        tbl[11] = mk("alu_nowe", 0, 3'b000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0,
                     32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk("sw",       2, SW, 32'h3C, 32'hCAFEBABE, 0, 14, 0, 1, 0,
                     0, 4'b1111, 32'hCAFEBABE, 32'h3C, 0, 0, 3, 2);
        tbl[13] = mk("lb_lane3", 1, LB, 32'h7, 0, 32'h80000000, 15, 1, 0, 0,
                     32'hFFFFFF80, 4'b0000, 0, 32'h4, 0, 1, 3, 2);
        tbl[14] = mk("sh_mis",   2, SH, 32'h3, 32'h77, 0, 16, 0, 0, 0,
                     0, 4'b0000, 0, 32'h0, 1, 0, 1, 0);

        rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_funct3 = '0;
        ex_mem_we = 1'b0; ex_mem_re = 1'b0; ex_rd = '0; ex_reg_we = 1'b0;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/wb_valid", wb_valid, 1'b0);
        chk("rst/wb_reg_we", wb_reg_we, 1'b0);
        chk("rst/wb_rd", wb_rd, 5'd0);
        chk("rst/wb_data", wb_data, 32'h0);
        chk("rst/misaligned", misaligned, 1'b0);
        chk("rst/dc_req_valid", dc_req_valid, 1'b0);
        chk("rst/stall", stall, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        for (int n = 0; n < 150; n++) begin
            v.name   = "rand";
            v.kind   = int'($urandom_range(0, 2));
            v.res    = $urandom();
            v.sdata  = $urandom();
            v.resp   = $urandom();
            v.rd     = 5'($urandom());
            v.reg_we = 1'($urandom());
            v.rdly   = int'($urandom_range(0, 3));
            v.wdly   = int'($urandom_range(0, 3));
            v.f3     = 3'($urandom());
            if (v.kind == 2) v.f3[2] = 1'b0;
            model(v);
            run(v);
        end

        // Load held off by 3 not-ready cycles with an ALU op waiting behind it
        @(negedge clk);
        ex_valid = 1'b1; ex_result = 32'h80; ex_funct3 = LW; ex_mem_we = 1'b0;
        ex_mem_re = 1'b1; ex_rd = 5'd9; ex_reg_we = 1'b1;
        load_k = 0; alu_k = 0; wb_cnt = 0; req_seen = 0; drop = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
            if (drop) begin ex_valid = 1'b0; drop = 0; end
            if (wb_valid) begin
                wb_cnt++;
                if (wb_rd == 5'd9) begin load_k = k; chk("b2b/load_data", wb_data, 32'hCAFEF00D); end
                if (wb_rd == 5'd3) begin alu_k = k; chk("b2b/alu_data", wb_data, 32'h5555); end
            end
            if (k == 1) begin
                ex_result = 32'h5555; ex_mem_re = 1'b0; ex_rd = 5'd3; ex_reg_we = 1'b1;
            end else if (ex_valid && !stall) begin
                drop = 1;
            end
            if (dc_req_valid) begin
                dc_req_ready = (req_seen == 3);
                req_seen++;
            end else if (stall) begin
                dc_resp_valid = 1'b1; dc_resp_data = 32'hCAFEF00D;
            end
        end
        ex_valid = 1'b0;
        chk("b2b/load_wb_cycle", load_k, 6);
        chk("b2b/alu_wb_cycle", alu_k, 7);
        chk("b2b/wb_count", wb_cnt, 2);

        // Reset while waiting for load data; a late response must be ignored
        @(negedge clk);
        ex_valid = 1'b1; ex_result = 32'h200; ex_funct3 = LB; ex_mem_we = 1'b0;
        ex_mem_re = 1'b1; ex_rd = 5'd4; ex_reg_we = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstwait/req_valid", dc_req_valid, 1'b1);
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0;
        chk("rstwait/in_wait_stall", stall, 1'b1);
        chk("rstwait/in_wait_req", dc_req_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait/req_after_rst", dc_req_valid, 1'b0);
        chk("rstwait/stall_after_rst", stall, 1'b0);
        chk("rstwait/wb_after_rst", wb_valid, 1'b0);
        dc_resp_valid = 1'b1; dc_resp_data = 32'h12345678;
        @(negedge clk);
        dc_resp_valid = 1'b0;
        chk("rstwait/late_resp_wb", wb_valid, 1'b0);
        chk("rstwait/late_resp_stall", stall, 1'b0);
        @(negedge clk);
        chk("rstwait/late_resp_wb2", wb_valid, 1'b0);
        run(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
